// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module  : dmem_pkg
// Brief   : Shared defaults, lock-state encoding and the memory request
//           record used by the data-memory arbiter slice.
// Revision: 1.0 - initial release
// ============================================================================
package dmem_pkg;

  // Default port widths and lock budget
  localparam int DMEM_ADDR_W   = 32;
  localparam int DMEM_DATA_W   = 32;
  localparam int DMEM_LOCK_MAX = 8;

  // Port-1 ownership state
  typedef enum logic [0:0] {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_e;

  // One memory access as presented by a requester
  typedef struct packed {
    logic                   we;
    logic [DMEM_ADDR_W-1:0] addr;
    logic [DMEM_DATA_W-1:0] wdata;
  } mem_req_t;

endpackage
`default_nettype wire

// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : dmem_arbiter_if
// Brief   : Two-requester data-memory bus. Port 0 is the core MEM stage,
//           port 1 is the DMA engine. The master modport is the requester
//           side, the slave modport is the arbiter side.
// Revision: 1.0 - initial release
// ============================================================================
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              m0_req;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_gnt;
  logic              m0_stall;
  logic              m0_rvalid;
  logic [DATA_W-1:0] m0_rdata;

  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_lock;
  logic              m1_gnt;
  logic              m1_rvalid;
  logic [DATA_W-1:0] m1_rdata;

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata, m1_lock,
    input  m0_gnt, m0_stall, m0_rvalid, m0_rdata,
    input  m1_gnt, m1_rvalid, m1_rdata
  );

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata, m1_lock,
    output m0_gnt, m0_stall, m0_rvalid, m0_rdata,
    output m1_gnt, m1_rvalid, m1_rdata
  );

endinterface
`default_nettype wire

// File: rtl/dmem_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module  : rr_arb2
// Brief   : Two-way combinational arbiter. A lone request always wins; on
//           contention the port named by prio wins.
// Revision: 1.0 - initial release
// ============================================================================
module rr_arb2 (
  input  wire logic [1:0] req,
  input  wire logic       prio,
  output logic      [1:0] gnt
);

  // Port 0 loses only when port 1 also requests and holds priority
  always_comb begin
    gnt    = 2'b00;
    gnt[0] = req[0] & (~req[1] | ~prio);
    gnt[1] = req[1] & (~req[0] |  prio);
  end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : dmem_arbiter
// Brief   : Arbitrates a single-port synchronous data RAM between the core
//           (port 0) and a DMA engine (port 1). Same-cycle grant, round-robin
//           on contention, bounded port-1 lock, one-cycle read return.
//           Optional contention counters: define DMEM_ARB_STATS_EN.
// Revision: 1.0 - initial release
// ============================================================================
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W   = DMEM_ADDR_W,
  parameter int DATA_W   = DMEM_DATA_W,
  parameter int LOCK_MAX = DMEM_LOCK_MAX
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  dmem_arbiter_if.slave          bus,
  output logic                   mem_en,
  output logic                   mem_we,
  output logic      [ADDR_W-1:0] mem_addr,
  output logic      [DATA_W-1:0] mem_wdata,
  input  wire logic [DATA_W-1:0] mem_rdata,
  output logic      [31:0]       stall_cnt0,
  output logic      [31:0]       stall_cnt1
);

  // Lock counter is one bit wider in the increment so LOCK_MAX itself fits
  localparam int                c_cnt_w    = $clog2(LOCK_MAX + 1);
  localparam logic [c_cnt_w:0]  c_lock_max = (c_cnt_w + 1)'(LOCK_MAX);
  localparam logic [c_cnt_w:0]  c_cnt_one  = (c_cnt_w + 1)'(1);

  logic [1:0]         w_req;
  logic [1:0]         w_gnt;
  logic               w_prio_eff;
  logic               w_stall0;
  logic               w_stall1;
  logic               w_rvalid0;
  logic               w_rvalid1;

  lock_state_e        r_lock_state;
  lock_state_e        w_lock_state_nxt;
  logic [c_cnt_w-1:0] r_lock_cnt;
  logic [c_cnt_w-1:0] w_lock_cnt_nxt;
  logic [c_cnt_w:0]   w_cnt_inc;
  logic               r_prio;
  logic               w_prio_nxt;
  logic               r_rd_pend;
  logic               r_rd_owner;

  // Requests are masked during reset so nothing is granted while rst_n is low
  assign w_req      = {bus.m1_req, bus.m0_req} & {2{rst_n}};
  assign w_prio_eff = (r_lock_state == LOCKED) ? 1'b1 : r_prio;

  rr_arb2 u_rr_arb2 (
    .req  (w_req),
    .prio (w_prio_eff),
    .gnt  (w_gnt)
  );

  assign bus.m0_gnt   = w_gnt[0];
  assign bus.m1_gnt   = w_gnt[1];
  assign w_stall0     = w_req[0] & ~w_gnt[0];
  assign w_stall1     = w_req[1] & ~w_gnt[1];
  assign bus.m0_stall = w_stall0;

  // Memory command is an AND-OR of the one-hot grant, so idle drives zero
  assign mem_en    = |w_gnt;
  assign mem_we    = (w_gnt[0] & bus.m0_we) | (w_gnt[1] & bus.m1_we);
  assign mem_addr  = ({ADDR_W{w_gnt[0]}} & bus.m0_addr)
                   | ({ADDR_W{w_gnt[1]}} & bus.m1_addr);
  assign mem_wdata = ({DATA_W{w_gnt[0]}} & bus.m0_wdata)
                   | ({DATA_W{w_gnt[1]}} & bus.m1_wdata);

  // Lock / priority state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lock_state <= UNLOCKED;
      r_lock_cnt   <= '0;
      r_prio       <= 1'b0;
    end else begin
      r_lock_state <= w_lock_state_nxt;
      r_lock_cnt   <= w_lock_cnt_nxt;
      r_prio       <= w_prio_nxt;
    end
  end

  // Next lock state, lock count and round-robin pointer
  always_comb begin
    w_lock_state_nxt = r_lock_state;
    w_lock_cnt_nxt   = r_lock_cnt;
    w_prio_nxt       = r_prio;
    w_cnt_inc        = {1'b0, r_lock_cnt} + c_cnt_one;

    if (w_gnt[0]) begin
      w_prio_nxt = 1'b1;
    end else if (w_gnt[1]) begin
      w_prio_nxt = 1'b0;
    end

    if (w_gnt[1] && bus.m1_lock) begin
      // The entering grant counts, so the budget covers LOCK_MAX grants total
      if (w_cnt_inc >= c_lock_max) begin
        w_lock_state_nxt = UNLOCKED;
        w_lock_cnt_nxt   = '0;
        w_prio_nxt       = 1'b0;
      end else begin
        w_lock_state_nxt = LOCKED;
        w_lock_cnt_nxt   = w_cnt_inc[c_cnt_w-1:0];
        w_prio_nxt       = 1'b1;
      end
    end else if (r_lock_state == LOCKED) begin
      // Port 1 dropped its request or its lock
      w_lock_state_nxt = UNLOCKED;
      w_lock_cnt_nxt   = '0;
    end
  end

  // Read-return tracking: pending flag plus owner tag, one cycle deep
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_pend  <= 1'b0;
      r_rd_owner <= 1'b0;
    end else begin
      r_rd_pend  <= mem_en & ~mem_we;
      r_rd_owner <= w_gnt[1];
    end
  end

  assign w_rvalid0     = r_rd_pend & ~r_rd_owner;
  assign w_rvalid1     = r_rd_pend &  r_rd_owner;
  assign bus.m0_rvalid = w_rvalid0;
  assign bus.m1_rvalid = w_rvalid1;
  assign bus.m0_rdata  = w_rvalid0 ? mem_rdata : '0;
  assign bus.m1_rdata  = w_rvalid1 ? mem_rdata : '0;

`ifdef DMEM_ARB_STATS_EN
  logic [31:0] r_stall_cnt0;
  logic [31:0] r_stall_cnt1;

  // Saturating per-port contention counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt0 <= '0;
      r_stall_cnt1 <= '0;
    end else begin
      if (w_stall0 && (r_stall_cnt0 != 32'hFFFF_FFFF)) begin
        r_stall_cnt0 <= r_stall_cnt0 + 32'd1;
      end
      if (w_stall1 && (r_stall_cnt1 != 32'hFFFF_FFFF)) begin
        r_stall_cnt1 <= r_stall_cnt1 + 32'd1;
      end
    end
  end

  assign stall_cnt0 = r_stall_cnt0;
  assign stall_cnt1 = r_stall_cnt1;
`else
  assign stall_cnt0 = '0;
  assign stall_cnt1 = '0;
`endif

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32: byte address width on all ports.
REQ-002 Parameter DATA_W, default 32: data width on all ports.
REQ-003 Parameter LOCK_MAX, default 8: maximum consecutive locked grants to port 1.
REQ-004 The block SHALL provide one clock and an asynchronous, active-low reset with the following ports:
- clk  in  1  sole clock; all state updates on its rising edge
- rst_n  in  1  asynchronous active-low reset
- m0_req / m1_req  in  1  access request, port 0 (core MEM stage) / port 1 (DMA)
- m0_we / m1_we  in  1  1 = write, 0 = read
- m0_addr / m1_addr  in  ADDR_W  access address
- m0_wdata / m1_wdata  in  DATA_W  write data
- m1_lock  in  1  port 1 requests back-to-back ownership
- m0_gnt / m1_gnt  out  1  request accepted this cycle
- m0_stall  out  1  m0_req & !m0_gnt; feeds the core hazard unit
- m0_rvalid / m1_rvalid  out  1  read data valid
- m0_rdata / m1_rdata  out  DATA_W  read data
- mem_en, mem_we  out  1  synchronous RAM enable / write enable
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, valid one cycle after mem_en & !mem_we
- stall_cnt0 / stall_cnt1  out  32  contention counters; see REQ-020

Function
REQ-005 Grant SHALL be combinational in the request cycle: at most one gnt high per cycle, and mem_en = m0_gnt | m1_gnt.
- mem_we, mem_addr and mem_wdata SHALL come from the granted port.
- When no port is granted, these outputs SHALL be 0.
REQ-006 A lone request SHALL be granted in the same cycle, regardless of priority state.
REQ-007 On simultaneous requests, the port named by the 1-bit priority pointer prio SHALL win.
REQ-008 After a grant to port i, prio SHALL become the other port; if no grant occurs, prio SHALL hold.
REQ-009 Lock state machine: UNLOCKED -> LOCKED when m1 is granted with m1_lock = 1.
- While LOCKED, prio SHALL remain 1, and each m1 grant SHALL increment lock_cnt.
- LOCKED -> UNLOCKED when m1_lock = 0, when m1_req = 0, or when lock_cnt reaches LOCK_MAX.
- On the LOCK_MAX exit, prio SHALL be forced to 0 for the next contended cycle.
REQ-010 Read latency SHALL be exactly one cycle: the cycle after a granted read, rvalid of the owning port SHALL be 1 and its rdata SHALL equal mem_rdata.
REQ-011 The owning port SHALL be held in a registered 1-bit tag plus a registered read-pending flag, so back-to-back reads (including alternating ports) produce rvalid every cycle.
REQ-012 Granted writes SHALL produce no rvalid.
REQ-013 rdata of a port SHALL be 0 whenever its rvalid is 0.
REQ-014 The requester SHALL hold req, we, addr and wdata stable until gnt. The arbiter SHALL NOT drop or reorder a held request.
REQ-015 A port-0 request SHALL be granted within 2 cycles when unlocked, and within LOCK_MAX+1 cycles otherwise.

Reset
REQ-016 On rst_n = 0, asynchronously:
- prio = 0, lock state = UNLOCKED, lock_cnt = 0
- read-pending flag = 0, owner tag = 0
- stall_cnt0 = stall_cnt1 = 0
REQ-017 While in reset, gnt, rvalid and mem_en SHALL all be 0.
REQ-018 A read granted in the cycle before reset assertion SHALL produce no rvalid.
REQ-019 The first post-reset grant SHALL follow REQ-006/REQ-007 with prio = 0.

Configuration
REQ-020 Macro DMEM_ARB_STATS_EN, when defined: stall_cntN SHALL increment by 1 each cycle mN_req & !mN_gnt, saturating at 32'hFFFF_FFFF.
- Without the macro, the counter logic SHALL be absent and stall_cnt0 = stall_cnt1 = 0, with ports retained.

Structure
REQ-021 Package dmem_pkg SHALL hold the ADDR_W and DATA_W defaults, the lock-state enum (UNLOCKED, LOCKED) and a mem_req_t struct {we, addr, wdata}.
REQ-022 Sub-module rr_arb2 (2-way round-robin: req[1:0], prio in -> gnt[1:0]) SHALL be instantiated once. Lock, latency and stats logic stays in dmem_arbiter.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Reset, then m0 read at addr 0x10 alone -> m0_gnt same cycle; next cycle m0_rvalid = 1, m0_rdata = RAM[0x10].
- m0 and m1 reads every cycle for 4 cycles, no lock -> grants alternate 0,1,0,1; rvalid alternates with correct data; m0_stall high on cycles 2 and 4.
- m1_lock = 1 with continuous m0 and m1 requests, LOCK_MAX = 8 -> 8 consecutive m1 grants, then m0 granted; stall_cnt0 = 8 with DMEM_ARB_STATS_EN.
- m0 write 0xDEADBEEF to 0x20, then m1 read of 0x20 -> no rvalid for the write; m1_rdata = 0xDEADBEEF.
- rst_n asserted in the cycle after a granted read -> no rvalid; all outputs 0; prio = 0 after release.
- Build without DMEM_ARB_STATS_EN and repeat the lock scenario -> stall_cnt0 = stall_cnt1 = 0 throughout.
